// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing, id helpers and opcode class encodings.
// Used by reorder_buffer and rob_operand_bypass.
package reorder_buffer_pkg;

  localparam int unsigned RobSize = 16;
  localparam int unsigned RobIdW  = 5;
  localparam int unsigned RobIdxW = 4;

  localparam logic [RobIdW-1:0] NonDependent = '0;

  localparam logic [5:0] OpLui   = 6'd0;
  localparam logic [5:0] OpAuipc = 6'd1;
  localparam logic [5:0] OpJal   = 6'd2;
  localparam logic [5:0] OpJalr  = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpBlt   = 6'd6;
  localparam logic [5:0] OpBge   = 6'd7;
  localparam logic [5:0] OpBltu  = 6'd8;
  localparam logic [5:0] OpBgeu  = 6'd9;
  localparam logic [5:0] OpLw    = 6'd12;
  localparam logic [5:0] OpSb    = 6'd15;
  localparam logic [5:0] OpSh    = 6'd16;
  localparam logic [5:0] OpSw    = 6'd17;
  localparam logic [5:0] OpAddi  = 6'd18;
  localparam logic [5:0] OpAdd   = 6'd27;

  function automatic logic is_store(logic [5:0] t);
    return (t == OpSb) || (t == OpSh) || (t == OpSw);
  endfunction

  function automatic logic is_ctrl(logic [5:0] t);
    return (t == OpJal) || (t == OpJalr) || ((t >= OpBeq) && (t <= OpBgeu));
  endfunction

  // Ids are entry index + 1 so that 0 can mean "no dependency".
  function automatic logic [RobIdxW-1:0] id_to_idx(logic [RobIdW-1:0] id);
    return RobIdxW'(id - RobIdW'(1));
  endfunction

  function automatic logic [RobIdW-1:0] idx_to_id(logic [RobIdxW-1:0] idx);
    return {1'b0, idx} + RobIdW'(1);
  endfunction

endpackage

// File: rtl/rob_operand_bypass.sv
// Operand lookup for one dispatcher query port: stored result or same-cycle CDB forward.
// Pure combinational; RS broadcast wins over LSB broadcast.
module rob_operand_bypass
  import reorder_buffer_pkg::*;
(
  input  logic [RobIdW-1:0]            qry_id_i,
  input  logic [RobSize-1:0]           done_i,
  input  logic [RobSize-1:0][31:0]     value_i,
  input  logic                         cdb_rs_en_i,
  input  logic [RobIdW-1:0]            cdb_rs_id_i,
  input  logic [31:0]                  cdb_rs_value_i,
  input  logic                         cdb_lsb_en_i,
  input  logic [RobIdW-1:0]            cdb_lsb_id_i,
  input  logic [31:0]                  cdb_lsb_value_i,
  output logic                         qry_rdy_o,
  output logic [31:0]                  qry_val_o
);

  logic [RobIdxW-1:0] idx;
  assign idx = id_to_idx(qry_id_i);

  always_comb begin
    qry_rdy_o = 1'b0;
    qry_val_o = '0;
    if (qry_id_i == NonDependent) begin
      qry_rdy_o = 1'b1;
    end else if (done_i[idx]) begin
      qry_rdy_o = 1'b1;
      qry_val_o = value_i[idx];
    end else if (cdb_rs_en_i && (cdb_rs_id_i == qry_id_i)) begin
      qry_rdy_o = 1'b1;
      qry_val_o = cdb_rs_value_i;
    end else if (cdb_lsb_en_i && (cdb_lsb_id_i == qry_id_i)) begin
      qry_rdy_o = 1'b1;
      qry_val_o = cdb_lsb_value_i;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement: allocation, CDB capture, head commit and mispredict flush.
// Optional build macro ROB_PERF_CNT_EN adds commit/mispredict performance counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        alloc_en,
  input  logic [5:0]  alloc_type,
  input  logic [4:0]  alloc_rd,
  input  logic [31:0] alloc_pc,
  input  logic [31:0] alloc_pred_pc,
  output logic [4:0]  alloc_rob_id,
  output logic        full_rob,
  input  logic [4:0]  qry_j_id,
  input  logic [4:0]  qry_k_id,
  output logic        qry_j_rdy,
  output logic        qry_k_rdy,
  output logic [31:0] qry_j_val,
  output logic [31:0] qry_k_val,
  input  logic        enable_cdb_rs,
  input  logic [4:0]  cdb_rs_rob_id,
  input  logic [31:0] cdb_rs_value,
  input  logic        cdb_rs_jump,
  input  logic [31:0] cdb_rs_pc_next,
  input  logic        enable_cdb_lsb,
  input  logic [4:0]  cdb_lsb_rob_id,
  input  logic [31:0] cdb_lsb_value,
  output logic        commit_en,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_value,
  output logic [4:0]  commit_rob_id,
  output logic        commit_store_en,
  output logic        mispredict,
  output logic [31:0] pc_redirect
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0] perf_commit_cnt,
  output logic [31:0] perf_mispredict_cnt
`endif
);

  logic [RobIdxW-1:0] head_q, head_d, tail_q, tail_d;
  logic [RobIdW-1:0]  count_q, count_d;
  logic [RobSize-1:0] busy_q, busy_d, done_q, done_d, jump_q, jump_d;
  logic [RobSize-1:0][5:0]  type_q, type_d;
  logic [RobSize-1:0][4:0]  rd_q, rd_d;
  logic [RobSize-1:0][31:0] pc_q, pc_d, pred_q, pred_d, pcn_q, pcn_d, val_q, val_d;

  logic        commit_en_q, commit_en_d, commit_store_en_q, commit_store_en_d;
  logic        mispredict_q, mispredict_d;
  logic [4:0]  commit_rd_q, commit_rd_d, commit_rob_id_q, commit_rob_id_d;
  logic [31:0] commit_value_q, commit_value_d, pc_redirect_q, pc_redirect_d;

  logic               do_commit, do_alloc;
  logic [RobIdxW-1:0] rs_idx, lsb_idx;
  logic [31:0]        resolved_pc;

  assign rs_idx       = id_to_idx(cdb_rs_rob_id);
  assign lsb_idx      = id_to_idx(cdb_lsb_rob_id);
  assign alloc_rob_id = idx_to_id(tail_q);
  assign full_rob     = (count_q == RobIdW'(RobSize));
  // A not-taken branch resolves to the fall-through PC.
  assign resolved_pc  = jump_q[head_q] ? pcn_q[head_q] : pc_q[head_q] + 32'd4;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    jump_d  = jump_q;
    type_d  = type_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    pred_d  = pred_q;
    pcn_d   = pcn_q;
    val_d   = val_q;
    commit_en_d       = 1'b0;
    commit_store_en_d = 1'b0;
    mispredict_d      = 1'b0;
    commit_rd_d       = commit_rd_q;
    commit_value_d    = commit_value_q;
    commit_rob_id_d   = commit_rob_id_q;
    pc_redirect_d     = pc_redirect_q;
    do_commit         = 1'b0;
    do_alloc          = 1'b0;
    if (rdy) begin
      if (enable_cdb_rs && (cdb_rs_rob_id != NonDependent) && busy_q[rs_idx]) begin
        done_d[rs_idx] = 1'b1;
        val_d[rs_idx]  = cdb_rs_value;
        jump_d[rs_idx] = cdb_rs_jump;
        pcn_d[rs_idx]  = cdb_rs_pc_next;
      end
      if (enable_cdb_lsb && (cdb_lsb_rob_id != NonDependent) && busy_q[lsb_idx]) begin
        done_d[lsb_idx] = 1'b1;
        val_d[lsb_idx]  = cdb_lsb_value;
      end

      // done_q (not done_d) enforces at least one cycle between CDB and commit.
      do_commit = busy_q[head_q] && done_q[head_q];
      do_alloc  = alloc_en && !full_rob;

      if (do_commit) begin
        busy_d[head_q]  = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + RobIdxW'(1);
        commit_rob_id_d = idx_to_id(head_q);
        commit_rd_d     = rd_q[head_q];
        commit_value_d  = val_q[head_q];
        if (is_store(type_q[head_q])) begin
          commit_store_en_d = 1'b1;
        end else if (rd_q[head_q] != 5'd0) begin
          commit_en_d = 1'b1;
        end
        if (is_ctrl(type_q[head_q]) && (resolved_pc != pred_q[head_q])) begin
          mispredict_d  = 1'b1;
          pc_redirect_d = resolved_pc;
        end
      end

      if (do_alloc) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        type_d[tail_q] = alloc_type;
        rd_d[tail_q]   = alloc_rd;
        pc_d[tail_q]   = alloc_pc;
        pred_d[tail_q] = alloc_pred_pc;
        tail_d         = tail_q + RobIdxW'(1);
      end

      count_d = count_q + RobIdW'(do_alloc) - RobIdW'(do_commit);

      if (mispredict_d) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        busy_d  = '0;
        done_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      busy_q            <= '0;
      done_q            <= '0;
      jump_q            <= '0;
      type_q            <= '0;
      rd_q              <= '0;
      pc_q              <= '0;
      pred_q            <= '0;
      pcn_q             <= '0;
      val_q             <= '0;
      commit_en_q       <= 1'b0;
      commit_store_en_q <= 1'b0;
      mispredict_q      <= 1'b0;
      commit_rd_q       <= '0;
      commit_value_q    <= '0;
      commit_rob_id_q   <= '0;
      pc_redirect_q     <= '0;
    end else begin
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      jump_q            <= jump_d;
      type_q            <= type_d;
      rd_q              <= rd_d;
      pc_q              <= pc_d;
      pred_q            <= pred_d;
      pcn_q             <= pcn_d;
      val_q             <= val_d;
      commit_en_q       <= commit_en_d;
      commit_store_en_q <= commit_store_en_d;
      mispredict_q      <= mispredict_d;
      commit_rd_q       <= commit_rd_d;
      commit_value_q    <= commit_value_d;
      commit_rob_id_q   <= commit_rob_id_d;
      pc_redirect_q     <= pc_redirect_d;
    end
  end

  assign commit_en       = commit_en_q;
  assign commit_store_en = commit_store_en_q;
  assign mispredict      = mispredict_q;
  assign commit_rd       = commit_rd_q;
  assign commit_value    = commit_value_q;
  assign commit_rob_id   = commit_rob_id_q;
  assign pc_redirect     = pc_redirect_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt_q, perf_commit_cnt_d;
  logic [31:0] perf_mispredict_cnt_q, perf_mispredict_cnt_d;

  always_comb begin
    perf_commit_cnt_d     = perf_commit_cnt_q + 32'(do_commit);
    perf_mispredict_cnt_d = perf_mispredict_cnt_q + 32'(mispredict_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_commit_cnt_q     <= '0;
      perf_mispredict_cnt_q <= '0;
    end else begin
      perf_commit_cnt_q     <= perf_commit_cnt_d;
      perf_mispredict_cnt_q <= perf_mispredict_cnt_d;
    end
  end

  assign perf_commit_cnt     = perf_commit_cnt_q;
  assign perf_mispredict_cnt = perf_mispredict_cnt_q;
`endif

  rob_operand_bypass u_bypass_j (
    .qry_id_i        (qry_j_id),
    .done_i          (done_q),
    .value_i         (val_q),
    .cdb_rs_en_i     (enable_cdb_rs),
    .cdb_rs_id_i     (cdb_rs_rob_id),
    .cdb_rs_value_i  (cdb_rs_value),
    .cdb_lsb_en_i    (enable_cdb_lsb),
    .cdb_lsb_id_i    (cdb_lsb_rob_id),
    .cdb_lsb_value_i (cdb_lsb_value),
    .qry_rdy_o       (qry_j_rdy),
    .qry_val_o       (qry_j_val)
  );

  rob_operand_bypass u_bypass_k (
    .qry_id_i        (qry_k_id),
    .done_i          (done_q),
    .value_i         (val_q),
    .cdb_rs_en_i     (enable_cdb_rs),
    .cdb_rs_id_i     (cdb_rs_rob_id),
    .cdb_rs_value_i  (cdb_rs_value),
    .cdb_lsb_en_i    (enable_cdb_lsb),
    .cdb_lsb_id_i    (cdb_lsb_rob_id),
    .cdb_lsb_value_i (cdb_lsb_value),
    .qry_rdy_o       (qry_k_rdy),
    .qry_val_o       (qry_k_val)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: commit order, wrap, flush, bypass and freeze.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk, rst, rdy, alloc_en;
  logic [5:0]  alloc_type;
  logic [4:0]  alloc_rd, alloc_rob_id;
  logic [31:0] alloc_pc, alloc_pred_pc;
  logic        full_rob;
  logic [4:0]  qry_j_id, qry_k_id;
  logic        qry_j_rdy, qry_k_rdy;
  logic [31:0] qry_j_val, qry_k_val;
  logic        enable_cdb_rs, cdb_rs_jump, enable_cdb_lsb;
  logic [4:0]  cdb_rs_rob_id, cdb_lsb_rob_id;
  logic [31:0] cdb_rs_value, cdb_rs_pc_next, cdb_lsb_value;
  logic        commit_en, commit_store_en, mispredict;
  logic [4:0]  commit_rd, commit_rob_id;
  logic [31:0] commit_value, pc_redirect;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt, perf_mispredict_cnt;
`endif

  int n_chk;
  int n_fail;

  reorder_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .alloc_en        (alloc_en),
    .alloc_type      (alloc_type),
    .alloc_rd        (alloc_rd),
    .alloc_pc        (alloc_pc),
    .alloc_pred_pc   (alloc_pred_pc),
    .alloc_rob_id    (alloc_rob_id),
    .full_rob        (full_rob),
    .qry_j_id        (qry_j_id),
    .qry_k_id        (qry_k_id),
    .qry_j_rdy       (qry_j_rdy),
    .qry_k_rdy       (qry_k_rdy),
    .qry_j_val       (qry_j_val),
    .qry_k_val       (qry_k_val),
    .enable_cdb_rs   (enable_cdb_rs),
    .cdb_rs_rob_id   (cdb_rs_rob_id),
    .cdb_rs_value    (cdb_rs_value),
    .cdb_rs_jump     (cdb_rs_jump),
    .cdb_rs_pc_next  (cdb_rs_pc_next),
    .enable_cdb_lsb  (enable_cdb_lsb),
    .cdb_lsb_rob_id  (cdb_lsb_rob_id),
    .cdb_lsb_value   (cdb_lsb_value),
    .commit_en       (commit_en),
    .commit_rd       (commit_rd),
    .commit_value    (commit_value),
    .commit_rob_id   (commit_rob_id),
    .commit_store_en (commit_store_en),
    .mispredict      (mispredict),
    .pc_redirect     (pc_redirect)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_commit_cnt     (perf_commit_cnt),
    .perf_mispredict_cnt (perf_mispredict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_en = 1'b0; alloc_type = '0; alloc_rd = '0; alloc_pc = '0; alloc_pred_pc = '0;
    qry_j_id = '0; qry_k_id = '0;
    enable_cdb_rs = 1'b0; cdb_rs_rob_id = '0; cdb_rs_value = '0; cdb_rs_jump = 1'b0;
    cdb_rs_pc_next = '0;
    enable_cdb_lsb = 1'b0; cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rdy = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_alloc(input logic [5:0] t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] pred);
    alloc_en = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred_pc = pred;
  endtask

  task automatic set_rs(input logic [4:0] id, input logic [31:0] v, input logic j,
                        input logic [31:0] pcn);
    enable_cdb_rs = 1'b1; cdb_rs_rob_id = id; cdb_rs_value = v; cdb_rs_jump = j;
    cdb_rs_pc_next = pcn;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    idle_inputs();
    tick();
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL rst_commit_en got %0h exp 0", commit_en); end
    n_chk++; if (commit_store_en !== 1'b0) begin n_fail++; $display("FAIL rst_store_en got %0h exp 0", commit_store_en); end
    n_chk++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mispredict got %0h exp 0", mispredict); end
    n_chk++; if (pc_redirect !== 32'h0) begin n_fail++; $display("FAIL rst_pc_redirect got %0h exp 0", pc_redirect); end
    n_chk++; if (full_rob !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0h exp 0", full_rob); end
    n_chk++; if (alloc_rob_id !== 5'd1) begin n_fail++; $display("FAIL rst_alloc_id got %0d exp 1", alloc_rob_id); end
    rst = 1'b1;
  endtask

  task automatic test_single_commit();
    do_reset();
    set_alloc(OpAddi, 5'd5, 32'h0, 32'h4);
    #1;
    n_chk++; if (alloc_rob_id !== 5'd1) begin n_fail++; $display("FAIL t1_alloc_id got %0d exp 1", alloc_rob_id); end
    tick();
    alloc_en = 1'b0;
    set_rs(5'd1, 32'h2A, 1'b0, 32'h4);
    tick();
    enable_cdb_rs = 1'b0;
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL t1_no_early_commit got %0h exp 0", commit_en); end
    tick();
    n_chk++; if (commit_en !== 1'b1) begin n_fail++; $display("FAIL t1_commit_en got %0h exp 1", commit_en); end
    n_chk++; if (commit_rd !== 5'd5) begin n_fail++; $display("FAIL t1_commit_rd got %0d exp 5", commit_rd); end
    n_chk++; if (commit_value !== 32'h2A) begin n_fail++; $display("FAIL t1_commit_value got %0h exp 2a", commit_value); end
    n_chk++; if (commit_rob_id !== 5'd1) begin n_fail++; $display("FAIL t1_commit_id got %0d exp 1", commit_rob_id); end
    n_chk++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL t1_mispredict got %0h exp 0", mispredict); end
    tick();
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_drop got %0h exp 0", commit_en); end
  endtask

  task automatic test_in_order();
    logic [31:0] exp_val [3];
    exp_val[0] = 32'h11; exp_val[1] = 32'h22; exp_val[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(OpAdd, 5'(i + 1), 32'(4 * i), 32'(4 * i + 4));
      #1;
      n_chk++; if (alloc_rob_id !== 5'(i + 1)) begin n_fail++; $display("FAIL t2_alloc_id got %0d exp %0d", alloc_rob_id, i + 1); end
      tick();
    end
    alloc_en = 1'b0;
    set_rs(5'd3, 32'h33, 1'b0, 32'hC);
    tick();
    set_rs(5'd1, 32'h11, 1'b0, 32'h4);
    tick();
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL t2_hold_for_head got %0h exp 0", commit_en); end
    set_rs(5'd2, 32'h22, 1'b0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      enable_cdb_rs = 1'b0;
      n_chk++; if (commit_en !== 1'b1) begin n_fail++; $display("FAIL t2_commit_en[%0d] got %0h exp 1", i, commit_en); end
      n_chk++; if (commit_rob_id !== 5'(i + 1)) begin n_fail++; $display("FAIL t2_commit_id[%0d] got %0d exp %0d", i, commit_rob_id, i + 1); end
      n_chk++; if (commit_value !== exp_val[i]) begin n_fail++; $display("FAIL t2_commit_val[%0d] got %0h exp %0h", i, commit_value, exp_val[i]); end
    end
    tick();
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL t2_drain got %0h exp 0", commit_en); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(OpAddi, 5'(i + 1), 32'(4 * i), 32'(4 * i + 4));
      #1;
      n_chk++; if (alloc_rob_id !== 5'(i + 1)) begin n_fail++; $display("FAIL t3_alloc_id got %0d exp %0d", alloc_rob_id, i + 1); end
      tick();
    end
    n_chk++; if (full_rob !== 1'b1) begin n_fail++; $display("FAIL t3_full got %0h exp 1", full_rob); end
    set_alloc(OpAddi, 5'd31, 32'h999, 32'h99D);
    tick();
    alloc_en = 1'b0;
    n_chk++; if (full_rob !== 1'b1) begin n_fail++; $display("FAIL t3_full_after_17th got %0h exp 1", full_rob); end
    set_rs(5'd1, 32'h100, 1'b0, 32'h4);
    tick();
    enable_cdb_rs = 1'b0;
    tick();
    n_chk++; if (commit_en !== 1'b1) begin n_fail++; $display("FAIL t3_commit_en got %0h exp 1", commit_en); end
    n_chk++; if (commit_rd !== 5'd1) begin n_fail++; $display("FAIL t3_commit_rd got %0d exp 1", commit_rd); end
    n_chk++; if (full_rob !== 1'b0) begin n_fail++; $display("FAIL t3_not_full got %0h exp 0", full_rob); end
    n_chk++; if (alloc_rob_id !== 5'd1) begin n_fail++; $display("FAIL t3_wrap_id got %0d exp 1", alloc_rob_id); end
    set_alloc(OpAddi, 5'd7, 32'h40, 32'h44);
    tick();
    alloc_en = 1'b0;
    n_chk++; if (full_rob !== 1'b1) begin n_fail++; $display("FAIL t3_refull got %0h exp 1", full_rob); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_alloc(OpBeq, 5'd0, 32'h100, 32'h104);
    tick();
    set_alloc(OpAddi, 5'd9, 32'h104, 32'h108);
    tick();
    alloc_en = 1'b0;
    set_rs(5'd1, 32'h0, 1'b1, 32'h140);
    tick();
    enable_cdb_rs = 1'b0;
    tick();
    n_chk++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL t4_mispredict got %0h exp 1", mispredict); end
    n_chk++; if (pc_redirect !== 32'h140) begin n_fail++; $display("FAIL t4_redirect got %0h exp 140", pc_redirect); end
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL t4_branch_no_wb got %0h exp 0", commit_en); end
    n_chk++; if (alloc_rob_id !== 5'd1) begin n_fail++; $display("FAIL t4_flush_tail got %0d exp 1", alloc_rob_id); end
    // Entry 2 was flushed, so a late broadcast to it must not mark it done.
    set_rs(5'd2, 32'h5, 1'b0, 32'h108);
    tick();
    enable_cdb_rs = 1'b0;
    qry_j_id = 5'd2;
    #1;
    n_chk++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL t4_pulse_drop got %0h exp 0", mispredict); end
    n_chk++; if (qry_j_rdy !== 1'b0) begin n_fail++; $display("FAIL t4_flushed_not_done got %0h exp 0", qry_j_rdy); end
    qry_j_id = 5'd0;

    set_alloc(OpJal, 5'd1, 32'h200, 32'h204);
    tick();
    alloc_en = 1'b0;
    set_rs(5'd1, 32'h204, 1'b1, 32'h300);
    tick();
    enable_cdb_rs = 1'b0;
    tick();
    n_chk++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL t4_jal_mispredict got %0h exp 1", mispredict); end
    n_chk++; if (pc_redirect !== 32'h300) begin n_fail++; $display("FAIL t4_jal_redirect got %0h exp 300", pc_redirect); end
    n_chk++; if (commit_en !== 1'b1) begin n_fail++; $display("FAIL t4_jal_link_en got %0h exp 1", commit_en); end
    n_chk++; if (commit_value !== 32'h204) begin n_fail++; $display("FAIL t4_jal_link_val got %0h exp 204", commit_value); end

    set_alloc(OpBne, 5'd0, 32'h300, 32'h304);
    tick();
    alloc_en = 1'b0;
    set_rs(5'd1, 32'h0, 1'b0, 32'h304);
    tick();
    enable_cdb_rs = 1'b0;
    tick();
    n_chk++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL t4_correct_pred got %0h exp 0", mispredict); end
    n_chk++; if (pc_redirect !== 32'h300) begin n_fail++; $display("FAIL t4_redirect_hold got %0h exp 300", pc_redirect); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_alloc(OpAddi, 5'd3, 32'h0, 32'h4);
    tick();
    set_alloc(OpLw, 5'd4, 32'h4, 32'h8);
    tick();
    alloc_en = 1'b0;
    qry_j_id = 5'd2; qry_k_id = 5'd0;
    enable_cdb_lsb = 1'b1; cdb_lsb_rob_id = 5'd2; cdb_lsb_value = 32'h77;
    #1;
    n_chk++; if (qry_j_rdy !== 1'b1) begin n_fail++; $display("FAIL t5_j_rdy got %0h exp 1", qry_j_rdy); end
    n_chk++; if (qry_j_val !== 32'h77) begin n_fail++; $display("FAIL t5_j_val got %0h exp 77", qry_j_val); end
    n_chk++; if (qry_k_rdy !== 1'b1 || qry_k_val !== 32'h0) begin n_fail++; $display("FAIL t5_k_nondep got %0h/%0h exp 1/0", qry_k_rdy, qry_k_val); end
    qry_k_id = 5'd1;
    #1;
    n_chk++; if (qry_k_rdy !== 1'b0) begin n_fail++; $display("FAIL t5_k_pending got %0h exp 0", qry_k_rdy); end
    set_rs(5'd2, 32'h99, 1'b0, 32'h4);
    #1;
    n_chk++; if (qry_j_val !== 32'h99) begin n_fail++; $display("FAIL t5_rs_priority got %0h exp 99", qry_j_val); end
    set_rs(5'd1, 32'h55, 1'b0, 32'h4);
    #1;
    n_chk++; if (qry_k_rdy !== 1'b1 || qry_k_val !== 32'h55) begin n_fail++; $display("FAIL t5_k_rs_fwd got %0h/%0h exp 1/55", qry_k_rdy, qry_k_val); end
    tick();
    idle_inputs();
    qry_j_id = 5'd2; qry_k_id = 5'd1;
    #1;
    n_chk++; if (qry_j_rdy !== 1'b1 || qry_j_val !== 32'h77) begin n_fail++; $display("FAIL t5_j_stored got %0h/%0h exp 1/77", qry_j_rdy, qry_j_val); end
    n_chk++; if (qry_k_rdy !== 1'b1 || qry_k_val !== 32'h55) begin n_fail++; $display("FAIL t5_k_stored got %0h/%0h exp 1/55", qry_k_rdy, qry_k_val); end
    qry_j_id = 5'd0; qry_k_id = 5'd0;
  endtask

  task automatic test_store_freeze();
    do_reset();
    set_alloc(OpSw, 5'd0, 32'h10, 32'h14);
    tick();
    set_alloc(OpSb, 5'd0, 32'h14, 32'h18);
    tick();
    alloc_en = 1'b0;
    enable_cdb_lsb = 1'b1; cdb_lsb_rob_id = 5'd1; cdb_lsb_value = 32'h0;
    tick();
    cdb_lsb_rob_id = 5'd2;
    tick();
    enable_cdb_lsb = 1'b0;
    n_chk++; if (commit_store_en !== 1'b1) begin n_fail++; $display("FAIL t6_store_en got %0h exp 1", commit_store_en); end
    n_chk++; if (commit_en !== 1'b0) begin n_fail++; $display("FAIL t6_store_no_wb got %0h exp 0", commit_en); end
    n_chk++; if (commit_rob_id !== 5'd1) begin n_fail++; $display("FAIL t6_store_id got %0d exp 1", commit_rob_id); end
    rdy = 1'b0;
    set_alloc(OpAddi, 5'd6, 32'h18, 32'h1C);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (commit_store_en !== 1'b0) begin n_fail++; $display("FAIL t6_frozen_store[%0d] got %0h exp 0", i, commit_store_en); end
      n_chk++; if (alloc_rob_id !== 5'd3) begin n_fail++; $display("FAIL t6_frozen_tail[%0d] got %0d exp 3", i, alloc_rob_id); end
    end
    rdy = 1'b1;
    alloc_en = 1'b0;
    tick();
    n_chk++; if (commit_store_en !== 1'b1) begin n_fail++; $display("FAIL t6_resume_store got %0h exp 1", commit_store_en); end
    n_chk++; if (commit_rob_id !== 5'd2) begin n_fail++; $display("FAIL t6_resume_id got %0d exp 2", commit_rob_id); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_single_commit();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_bypass();
    test_store_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
